// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared FSM state type and counter-width helper for the
//                bit-serial adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // Controller states of the bit-serial adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that can represent every value 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : Single-bit full adder built from two half adders and an OR.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (s0),
        .carry (c0)
    );

    half_adder u_ha1 (
        .a     (s0),
        .b     (cin),
        .sum   (sum),
        .carry (c1)
    );

    // At most one of the two half-adder carries can be set.
    assign cout = c0 | c1;

endmodule
`default_nettype wire

// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
//  Module      : half_adder
//  Description : Single-bit half adder (sum = a^b, carry = a&b).
//  Revision    : 1.0 - initial release
// ============================================================================
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial WIDTH-bit adder. Operands are captured on an
//                accepted start, one bit is summed per RUN cycle through a
//                single full adder, and done pulses for one cycle when the
//                registered sum/cout are valid (latency WIDTH+1).
//  Options     : SERIAL_ADDER_SUB_EN - adds a 'sub' input; when set on start
//                the block computes a-b (cout=1 means no borrow).
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                 CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   b_load;
    logic               carry_load;

    // Select the b operand and initial carry loaded on start (add or subtract).
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        b_load     = sub ? ~b : b;
        carry_load = sub;
`else
        b_load     = b;
        carry_load = 1'b0;
`endif
    end

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs; start is only honoured in IDLE.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST_BIT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture on start, then shift one bit per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    sum   <= {fa_sum, sum[WIDTH-1:1]};
                    carry <= fa_cout;
                    cnt   <= cnt + 1'b1;
                    // The carry out of the final bit becomes the visible cout.
                    if (cnt == LAST_BIT) begin
                        cout <= fa_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder (WIDTH=8 and WIDTH=32
//                instances) against an arithmetic reference model.
//  Options     : SERIAL_ADDER_SUB_EN - also exercises subtraction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8;
    logic        start32;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [31:0] a32;
    logic [31:0] b32;
`ifdef SERIAL_ADDER_SUB_EN
    logic        sub8;
`endif
    logic        busy8;
    logic        done8;
    logic [7:0]  sum8;
    logic        cout8;
    logic        busy32;
    logic        done32;
    logic [31:0] sum32;
    logic        cout32;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub8),
`endif
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start32),
        .a     (a32),
        .b     (b32),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (1'b0),
`endif
        .busy  (busy32),
        .done  (done32),
        .sum   (sum32),
        .cout  (cout32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One complete operation on the selected instance; called right after a
    // falling edge with the instance idle.
    task automatic op(input bit wide, input logic [63:0] xa, input logic [63:0] xb,
                      input logic xsub, input bit scramble);
        int          w;
        int          n;
        int          nb;
        logic [63:0] mask;
        logic [63:0] tot;
        logic [63:0] es;
        logic        ec;
        logic        d;
        logic        bz;
        logic [63:0] s;
        logic        c;

        w    = wide ? 32 : 8;
        mask = (64'd1 << w) - 64'd1;
        if (xsub) begin
            es = (xa - xb) & mask;
            ec = ((xa & mask) >= (xb & mask));
        end else begin
            tot = (xa & mask) + (xb & mask);
            es  = tot & mask;
            ec  = tot[w];
        end

        if (wide) begin
            a32 = xa[31:0]; b32 = xb[31:0]; start32 = 1'b1;
        end else begin
            a8 = xa[7:0]; b8 = xb[7:0]; start8 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
            sub8 = xsub;
`endif
        end
        @(posedge clk);
        #1;
        start8  = 1'b0;
        start32 = 1'b0;

        n  = 0;
        nb = 0;
        do begin
            @(negedge clk);
            n++;
            d  = wide ? done32 : done8;
            bz = wide ? busy32 : busy8;
            if (bz) nb++;
            if (scramble) begin
                a8  = 8'($urandom);
                b8  = 8'($urandom);
                a32 = $urandom;
                b32 = $urandom;
            end
        end while (!d && n < 3 * w);

        s = wide ? 64'(sum32) : 64'(sum8);
        c = wide ? cout32 : cout8;
        check("latency", 64'(n), 64'(w + 1));
        check("busy_cycles", 64'(nb), 64'(w + 1));
        check("sum", s, es);
        check("cout", 64'(c), 64'(ec));

        a8  = 8'($urandom);
        b8  = 8'($urandom);
        a32 = $urandom;
        b32 = $urandom;
        @(negedge clk);
        d  = wide ? done32 : done8;
        bz = wide ? busy32 : busy8;
        s  = wide ? 64'(sum32) : 64'(sum8);
        c  = wide ? cout32 : cout8;
        check("done_one_cycle", 64'(d), 64'd0);
        check("idle_after_done", 64'(bz), 64'd0);
        check("sum_hold", s, es);
        check("cout_hold", 64'(c), 64'(ec));
    endtask

    logic [7:0] bb_a [3];
    logic [7:0] bb_b [3];

    initial begin
        int n;
        int dn;
        logic [63:0] es;

        rst_n   = 1'b0;
        start8  = 1'b0;
        start32 = 1'b0;
        a8 = '0; b8 = '0; a32 = '0; b32 = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b0;
`endif
        #2;
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_done8", 64'(done8), 64'd0);
        check("rst_sum8", 64'(sum8), 64'd0);
        check("rst_cout8", 64'(cout8), 64'd0);
        check("rst_busy32", 64'(busy32), 64'd0);
        check("rst_sum32", 64'(sum32), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        op(1'b0, 64'h05, 64'h03, 1'b0, 1'b0);
        op(1'b0, 64'hFF, 64'h01, 1'b0, 1'b0);
        op(1'b0, 64'h3C, 64'h41, 1'b0, 1'b1);
        op(1'b0, 64'h00, 64'h00, 1'b0, 1'b0);

        // start held high: three back-to-back operations.
        bb_a[0] = 8'h10; bb_b[0] = 8'h20;
        bb_a[1] = 8'h7F; bb_b[1] = 8'h01;
        bb_a[2] = 8'h80; bb_b[2] = 8'h80;
        a8 = bb_a[0]; b8 = bb_b[0]; start8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done8 && n < 40);
            es = 64'(bb_a[i]) + 64'(bb_b[i]);
            check("b2b_spacing", 64'(n), (i == 0) ? 64'd9 : 64'd10);
            check("b2b_sum", 64'(sum8), es & 64'hFF);
            check("b2b_cout", 64'(cout8), 64'(es[8]));
            if (i < 2) begin
                a8 = bb_a[i+1];
                b8 = bb_b[i+1];
            end
        end
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Randomized 8-bit and 32-bit operations.
        for (int i = 0; i < 12; i++) begin
            op(1'b0, 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)), 1'b0, 1'($urandom));
        end
        for (int i = 0; i < 3; i++) begin
            op(1'b1, 64'($urandom), 64'($urandom), 1'b0, 1'($urandom));
        end

`ifdef SERIAL_ADDER_SUB_EN
        op(1'b0, 64'h05, 64'h07, 1'b1, 1'b0);
        op(1'b0, 64'h07, 64'h05, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            op(1'b0, 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)), 1'($urandom), 1'b0);
        end
`endif

        // Leave dut8 holding cout=1, then reset dut32 mid-RUN.
        op(1'b0, 64'hFF, 64'h01, 1'b0, 1'b0);
        a32 = 32'hFFFF_FFFF; b32 = 32'h0; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("pre_rst_sum32", 64'(sum32), 64'hFFF0_0000);
        check("pre_rst_cout8", 64'(cout8), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_sum32", 64'(sum32), 64'd0);
        check("async_rst_busy32", 64'(busy32), 64'd0);
        check("async_rst_done32", 64'(done32), 64'd0);
        check("async_rst_cout8", 64'(cout8), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) dn++;
        end
        check("no_done_after_abort", 64'(dn), 64'd0);
        op(1'b1, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled in IDLE only.
REQ-005 SHALL have port a  input  WIDTH  first operand, captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  second operand, captured on accepted start.
REQ-007 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-009 SHALL have port sum  output  WIDTH  registered result.
REQ-010 SHALL have port cout  output  1  registered carry out of bit WIDTH-1.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 IDLE with start=1 at a rising edge SHALL capture a, b into shift registers, clear the carry flop (or load per REQ-027), clear the bit counter, clear sum and cout, and enter RUN.
REQ-013 Each RUN cycle SHALL add operand LSBs plus carry flop via one full-adder instance, shift both operands right by one, shift the sum bit into sum MSB (sum shifts right), update the carry flop, increment the counter.
REQ-014 After the WIDTH-th RUN cycle, the FSM SHALL enter DONE, with cout loaded from the final carry.
REQ-015 DONE SHALL assert done for exactly one cycle, then return unconditionally to IDLE.
REQ-016 Latency SHALL be WIDTH+1 cycles: start accepted at edge k produces done high during the cycle after edge k+WIDTH.
REQ-017 start while busy=1 SHALL be ignored, including start asserted during DONE.
REQ-018 start held high continuously SHALL launch a new operation on the first IDLE edge after done, giving back-to-back throughput of one result per WIDTH+2 cycles.
REQ-019 sum and cout SHALL hold their values from DONE until the next accepted start.
REQ-020 Arithmetic SHALL be unsigned modulo 2^WIDTH, with cout equal to bit WIDTH of the true sum.
REQ-021 Changes on a and b after capture SHALL NOT affect the result in progress.

Reset
REQ-022 Asserting rst_n low SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, carry flop=0, counter=0, independent of clk.
REQ-023 Reset asserted mid-RUN SHALL abandon the operation; no done SHALL be produced for it.
REQ-024 After rst_n deasserts, the first accepted start SHALL behave identically to one following a normal completion.

Configuration
REQ-025 Macro SERIAL_ADDER_SUB_EN SHALL control subtraction support.
REQ-026 Without SERIAL_ADDER_SUB_EN, there SHALL be no sub port, and the block SHALL only add.
REQ-027 With SERIAL_ADDER_SUB_EN, a 1-bit input sub SHALL be captured on start; when sub=1, the block SHALL load the captured b inverted, preset the carry flop to 1, and return a-b mod 2^WIDTH, with cout=1 meaning no borrow.

Structure
REQ-028 A shared package serial_adder_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the counter-width function/constant based on $clog2(WIDTH+1).
REQ-029 The single-bit adder SHALL be one sub-module, full_adder, built from two existing half_adder instances plus an OR; it SHALL be instantiated once.

Verification
REQ-030 WIDTH=8, a=0x05, b=0x03, start pulsed -> done exactly 9 cycles after the start edge, sum=0x08, cout=0.
REQ-031 WIDTH=8, a=0xFF, b=0x01 -> sum=0x00, cout=1; busy high 9 cycles.
REQ-032 WIDTH=8, start held high through three operations (0x10+0x20, 0x7F+0x01, 0x80+0x80) -> results 0x30/0, 0x80/0, 0x00/1, with done spaced 10 cycles apart; start during RUN/DONE ignored.
REQ-033 WIDTH=32, start accepted, rst_n pulsed low at RUN cycle 12 -> outputs zero asynchronously, no done; a subsequent 0xFFFFFFFF+0x1 -> sum=0, cout=1.
REQ-034 WIDTH=8, a/b changed every cycle during RUN after capture of 0x3C+0x41 -> sum=0x7D.
REQ-035 With SERIAL_ADDER_SUB_EN, WIDTH=8: 0x05-0x07 -> sum=0xFE, cout=0; 0x07-0x05 -> sum=0x02, cout=1.
